shape_rasterizer: RTL

- Draw-command front end for the frame buffer color map; sits directly upstream of it.
- Accepts one rectangle or filled-circle command at a time and emits one pixel write per cycle: linear address y*WIDTH+x plus color index.
- Downstream write port may stall; shapes are clipped to the screen.

---
 rtl/raster_pkg.sv | 37 +++
 rtl/shape_rasterizer_if.sv | 39 +++
 rtl/raster_clip.sv | 56 +++++
 rtl/shape_rasterizer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared types and constants for the shape rasterizer and its clip helper.
//   shape_e  : draw command shape selector
//   state_e  : rasterizer FSM states
//   color_t  : color index type
//   clamp_coord() : clamp a signed coordinate into [0, hi]
package raster_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 10;
  localparam int COLOR_W  = 4;

  typedef enum logic {
    SHAPE_RECT   = 1'b0,
    SHAPE_CIRCLE = 1'b1
  } shape_e;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SCAN,
    DONE
  } state_e;

  typedef logic [COLOR_W-1:0] color_t;

  function automatic logic [COORD_W-1:0] clamp_coord(input logic signed [11:0] v,
                                                     input logic [COORD_W-1:0] hi);
    if (v < 12'sd0)
      return '0;
    else if (v > $signed({2'b00, hi}))
      return hi;
    else
      return v[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/shape_rasterizer_if.sv
// Command + pixel-write bus of the shape rasterizer.
//   cmd_*    : draw command (valid/ready handshake)
//   wr_*     : pixel write port toward the frame buffer, wr_stall from it
// master : command source / write sink (testbench or upstream logic)
// slave  : the rasterizer
interface shape_rasterizer_if #(
  parameter int COLOR_W = 4,
  parameter int ADDR_W  = 19
);
  import raster_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  shape_e             cmd_shape;
  logic [9:0]         cmd_x0;
  logic [9:0]         cmd_y0;
  logic [9:0]         cmd_x1;
  logic [9:0]         cmd_y1;
  logic [8:0]         cmd_r;
  logic [COLOR_W-1:0] cmd_color;

  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic               wr_stall;

  modport master (
    output cmd_valid, cmd_shape, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_r, cmd_color,
    output wr_stall,
    input  cmd_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  cmd_valid, cmd_shape, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_r, cmd_color,
    input  wr_stall,
    output cmd_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/raster_clip.sv
// Combinational bounding-box computation and screen clipping.
//   i_shape            : rectangle or filled circle
//   i_x0/i_y0          : rect top-left (inclusive) / circle center
//   i_x1/i_y1          : rect bottom-right (exclusive), unused for circle
//   i_r                : circle radius, unused for rect
//   o_xmin..o_ymax     : clipped inclusive box, valid when !o_empty
//   o_empty            : nothing of the shape lies on screen
module raster_clip
  import raster_pkg::*;
#(
  parameter int WIDTH  = SCREEN_W,
  parameter int HEIGHT = SCREEN_H
) (
  input  shape_e             i_shape,
  input  logic [COORD_W-1:0] i_x0,
  input  logic [COORD_W-1:0] i_y0,
  input  logic [COORD_W-1:0] i_x1,
  input  logic [COORD_W-1:0] i_y1,
  input  logic [8:0]         i_r,
  output logic [COORD_W-1:0] o_xmin,
  output logic [COORD_W-1:0] o_xmax,
  output logic [COORD_W-1:0] o_ymin,
  output logic [COORD_W-1:0] o_ymax,
  output logic               o_empty
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

  // 12-bit signed keeps cx+r (up to 1534) and cx-r (down to -511) exact.
  logic signed [11:0] w_xlo, w_xhi, w_ylo, w_yhi;

  always_comb begin
    w_xlo = $signed({2'b00, i_x0});
    w_ylo = $signed({2'b00, i_y0});
    w_xhi = $signed({2'b00, i_x1}) - 12'sd1;
    w_yhi = $signed({2'b00, i_y1}) - 12'sd1;
    if (i_shape == SHAPE_CIRCLE) begin
      w_xlo = $signed({2'b00, i_x0}) - $signed({3'b000, i_r});
      w_xhi = $signed({2'b00, i_x0}) + $signed({3'b000, i_r});
      w_ylo = $signed({2'b00, i_y0}) - $signed({3'b000, i_r});
      w_yhi = $signed({2'b00, i_y0}) + $signed({3'b000, i_r});
    end
  end

  assign o_empty = (w_xhi < w_xlo) || (w_yhi < w_ylo) ||
                   (w_xhi < 12'sd0) || (w_yhi < 12'sd0) ||
                   (w_xlo > $signed({2'b00, X_LAST})) ||
                   (w_ylo > $signed({2'b00, Y_LAST}));

  assign o_xmin = clamp_coord(w_xlo, X_LAST);
  assign o_xmax = clamp_coord(w_xhi, X_LAST);
  assign o_ymin = clamp_coord(w_ylo, Y_LAST);
  assign o_ymax = clamp_coord(w_yhi, Y_LAST);

endmodule

// File: rtl/shape_rasterizer.sv
// Draw-command front end: turns one rectangle / filled-circle command into
// one pixel write per cycle (addr = y*WIDTH+x), clipped to the screen.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of shape_rasterizer_if (command in, pixel writes out)
//   o_busy   : command in progress
//   o_done   : one-cycle pulse when a command completes
module shape_rasterizer
  import raster_pkg::*;
#(
  parameter int WIDTH   = SCREEN_W,
  parameter int HEIGHT  = SCREEN_H,
  parameter int COLOR_W = 4,
  parameter int ADDR_W  = 19
) (
  input  logic                clk,
  input  logic                rst,
  shape_rasterizer_if.slave   bus,
  output logic                o_busy,
  output logic                o_done
);

  state_e             r_state;
  shape_e             r_shape;
  logic [9:0]         r_x0, r_y0, r_x1, r_y1;
  logic [8:0]         r_r;
  logic [COLOR_W-1:0] r_color;
  logic [9:0]         r_x, r_y;
  logic [ADDR_W-1:0]  r_row_base;
  logic [20:0]        r_r2;
  logic               r_fin;   // last box pixel already issued (or box empty)
  logic               r_cmd_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [COLOR_W-1:0] r_wr_data;

  logic [9:0]         w_xmin, w_xmax, w_ymin, w_ymax;
  logic               w_empty;
  logic signed [20:0] w_dx, w_dy;
  logic [20:0]        w_dx2, w_dy2, w_dist;
  logic               w_hit;

  raster_clip #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_clip (
    .i_shape (r_shape),
    .i_x0    (r_x0),
    .i_y0    (r_y0),
    .i_x1    (r_x1),
    .i_y1    (r_y1),
    .i_r     (r_r),
    .o_xmin  (w_xmin),
    .o_xmax  (w_xmax),
    .o_ymin  (w_ymin),
    .o_ymax  (w_ymax),
    .o_empty (w_empty)
  );

  // Inside the box |dx|,|dy| <= r <= 511, so the sum stays below 2^20.
  assign w_dx   = $signed({11'b0, r_x}) - $signed({11'b0, r_x0});
  assign w_dy   = $signed({11'b0, r_y}) - $signed({11'b0, r_y0});
  assign w_dx2  = w_dx * w_dx;
  assign w_dy2  = w_dy * w_dy;
  assign w_dist = w_dx2 + w_dy2;
  assign w_hit  = (r_shape == SHAPE_RECT) || (w_dist <= r_r2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shape     <= SHAPE_RECT;
      r_x0        <= '0;
      r_y0        <= '0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_r         <= '0;
      r_color     <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_row_base  <= '0;
      r_r2        <= '0;
      r_fin       <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid && r_cmd_ready) begin
            r_shape     <= bus.cmd_shape;
            r_x0        <= bus.cmd_x0;
            r_y0        <= bus.cmd_y0;
            r_x1        <= bus.cmd_x1;
            r_y1        <= bus.cmd_y1;
            r_r         <= bus.cmd_r;
            r_color     <= bus.cmd_color;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          // An empty box passes through SCAN once so done lands on the same
          // cadence as a finished scan, without ever raising wr_en.
          r_fin      <= w_empty;
          r_x        <= w_xmin;
          r_y        <= w_ymin;
          r_row_base <= ADDR_W'(w_ymin) * ADDR_W'(WIDTH);
          r_r2       <= {12'b0, r_r} * {12'b0, r_r};
          r_state    <= SCAN;
        end
        SCAN: begin
          if (!(r_wr_en && bus.wr_stall)) begin
            if (r_fin) begin
              r_wr_en <= 1'b0;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= DONE;
            end else begin
              r_wr_en   <= w_hit;
              r_wr_addr <= r_row_base + ADDR_W'(r_x);
              r_wr_data <= r_color;
              if (r_x == w_xmax) begin
                r_x        <= w_xmin;
                r_row_base <= r_row_base + ADDR_W'(WIDTH);
                if (r_y == w_ymax)
                  r_fin <= 1'b1;
                else
                  r_y <= r_y + 10'd1;
              end else begin
                r_x <= r_x + 10'd1;
              end
            end
          end
        end
        DONE: begin
          r_done      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule
